// File: rtl/ustawienie_sync.sv
// ustawienie_sync: registered bit-set of A at signed index B, with out-of-range error
// ports: i_clk/i_rst (sync, active-high) | i_valid, i_arg_A, i_arg_B in |
//        o_result = A | (1<<B) or 0, o_error = B outside [0,BITS-1], o_valid, all registered
module ustawienie_sync #(
  parameter int BITS = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_valid,
  input  logic [BITS-1:0] i_arg_A,
  input  logic [BITS-1:0] i_arg_B,
  output logic [BITS-1:0] o_result,
  output logic            o_error,
  output logic            o_valid
);
  localparam logic [BITS-1:0] LIM = BITS[BITS-1:0];
  localparam logic [BITS-1:0] ONE = {{(BITS-1){1'b0}}, 1'b1};
  logic [BITS-1:0] result_q, result_d;
  logic            error_q, error_d, valid_q, valid_d, in_range;
  // a negative B has its sign bit set, so an unsigned compare rejects it too
  always_comb begin
    in_range = i_arg_B < LIM;
    result_d = i_valid ? (in_range ? (i_arg_A | (ONE << i_arg_B)) : '0) : result_q;
    error_d  = i_valid ? !in_range : error_q;
    valid_d  = i_valid;
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      result_q <= '0;
      error_q  <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      result_q <= result_d;
      error_q  <= error_d;
      valid_q  <= valid_d;
    end
  end
  assign o_result = result_q;
  assign o_error  = error_q;
  assign o_valid  = valid_q;
endmodule

// File: tb/tb_ustawienie_sync.sv
// tb_ustawienie_sync: directed-vector bench for ustawienie_sync
module tb_ustawienie_sync;
  logic        clk = 1'b0;
  logic        rst, valid;
  logic [31:0] a, b, o_result;
  logic        o_error, o_valid;
  int          vectors = 0;
  int          miscompares = 0;

  ustawienie_sync #(.BITS(32)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_arg_A(a), .i_arg_B(b),
    .o_result(o_result), .o_error(o_error), .o_valid(o_valid)
  );

  always #5 clk = ~clk;

  task automatic step(input logic r, input logic v, input logic [31:0] av, input logic [31:0] bv);
    @(negedge clk);
    rst = r; valid = v; a = av; b = bv;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b1, 32'hFFFFFFFF, 32'd0);
      vectors++;
      if ({o_result, o_error, o_valid} !== 34'd0) begin
        miscompares++;
        $display("FAIL reset[%0d] got r=%h e=%b v=%b want r=0 e=0 v=0", i, o_result, o_error, o_valid);
      end
    end
  endtask

  task automatic test_in_range();
    logic [31:0] bs [3];
    logic [31:0] ex [3];
    bs = '{32'd0, 32'd5, 32'd31};
    ex = '{32'h00000001, 32'h00000020, 32'h80000000};
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 32'd0, bs[i]);
      vectors++;
      if ({o_result, o_error, o_valid} !== {ex[i], 2'b01}) begin
        miscompares++;
        $display("FAIL in_range[%0d] got r=%h e=%b v=%b want r=%h e=0 v=1", i, o_result, o_error, o_valid, ex[i]);
      end
    end
  endtask

  task automatic test_passthrough();
    logic [31:0] as [2];
    logic [31:0] bs [2];
    logic [31:0] ex [2];
    as = '{32'h000000F0, 32'hA5A50000};
    bs = '{32'd4, 32'd0};
    ex = '{32'h000000F0, 32'hA5A50001};
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b1, as[i], bs[i]);
      vectors++;
      if ({o_result, o_error, o_valid} !== {ex[i], 2'b01}) begin
        miscompares++;
        $display("FAIL passthrough[%0d] got r=%h e=%b v=%b want r=%h e=0 v=1", i, o_result, o_error, o_valid, ex[i]);
      end
    end
  endtask

  task automatic test_negative();
    logic [31:0] bs [3];
    bs = '{32'hFFFFFFFF, 32'h80000001, 32'hFFFFFFF0};
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 32'd0, bs[i]);
      vectors++;
      if ({o_result, o_error, o_valid} !== {32'd0, 2'b11}) begin
        miscompares++;
        $display("FAIL negative[%0d] got r=%h e=%b v=%b want r=0 e=1 v=1", i, o_result, o_error, o_valid);
      end
    end
  endtask

  task automatic test_too_large();
    logic [31:0] bs [3];
    bs = '{32'd32, 32'd33, 32'h7FFFFFFF};
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 32'd0, bs[i]);
      vectors++;
      if ({o_result, o_error, o_valid} !== {32'd0, 2'b11}) begin
        miscompares++;
        $display("FAIL too_large[%0d] got r=%h e=%b v=%b want r=0 e=1 v=1", i, o_result, o_error, o_valid);
      end
    end
    step(1'b0, 1'b1, 32'd0, 32'd31);
    vectors++;
    if ({o_result, o_error, o_valid} !== {32'h80000000, 2'b01}) begin
      miscompares++;
      $display("FAIL error_clear got r=%h e=%b v=%b want r=80000000 e=0 v=1", o_result, o_error, o_valid);
    end
  endtask

  task automatic test_hold_error();
    step(1'b0, 1'b1, 32'h12345678, 32'd40);
    step(1'b0, 1'b0, 32'hFFFFFFFF, 32'd1);
    vectors++;
    if ({o_result, o_error, o_valid} !== {32'd0, 2'b10}) begin
      miscompares++;
      $display("FAIL hold_error got r=%h e=%b v=%b want r=0 e=1 v=0", o_result, o_error, o_valid);
    end
  endtask

  task automatic test_hold_reset();
    step(1'b0, 1'b1, 32'd0, 32'd3);
    vectors++;
    if ({o_result, o_error, o_valid} !== {32'd8, 2'b01}) begin
      miscompares++;
      $display("FAIL hold_op got r=%h e=%b v=%b want r=8 e=0 v=1", o_result, o_error, o_valid);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 32'hFFFFFFFF, 32'd7);
      vectors++;
      if ({o_result, o_error, o_valid} !== {32'd8, 2'b00}) begin
        miscompares++;
        $display("FAIL hold[%0d] got r=%h e=%b v=%b want r=8 e=0 v=0", i, o_result, o_error, o_valid);
      end
    end
    step(1'b1, 1'b1, 32'hFFFFFFFF, 32'd2);
    vectors++;
    if ({o_result, o_error, o_valid} !== 34'd0) begin
      miscompares++;
      $display("FAIL mid_reset got r=%h e=%b v=%b want r=0 e=0 v=0", o_result, o_error, o_valid);
    end
  endtask

  initial begin
    rst = 1'b1; valid = 1'b0; a = '0; b = '0;
    test_reset();
    test_in_range();
    test_passthrough();
    test_negative();
    test_too_large();
    test_hold_error();
    test_hold_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/ustawienie_sync.md
Name: ustawienie_sync

Overview:
- Clocked bit-set unit of the synchronous arithmetic unit: sets the bit of operand A selected by index operand B to 1.
- Flags an error when B is not a valid bit index, i.e. B is negative or B ≥ BITS.
- Result and error are registered, 1-cycle latency; stand-alone operation block selected by the arithmetic unit's top level.

Parameters:
- BITS, 32, operand/result width; B is interpreted as a signed BITS-bit two's-complement value; BITS ≥ 2.

Ports:
- i_clk  input  1  system clock, all state updates on rising edge
- i_rst  input  1  synchronous, active-high reset
- i_valid  input  1  operands valid this cycle; capture request
- i_arg_A  input  BITS  source word
- i_arg_B  input  BITS  bit index, signed two's complement
- o_result  output  BITS  A with bit B forced to 1 (registered)
- o_error  output  1  index out of range (registered)
- o_valid  output  1  o_result/o_error updated this cycle (registered)

Behaviour:
- Reset: synchronous, active-high; rising edge with i_rst=1 forces o_result='0, o_error=0, o_valid=0.
- Reset priority: reset overrides i_valid in the same cycle; reset mid-operation discards the pending operand.
- Capture: on a rising edge with i_rst=0 and i_valid=1, the outputs update on that edge as follows.
  - In range, 0 ≤ signed(B) ≤ BITS-1: o_result = A | (1 << B), o_error=0.
  - A bit already 1 stays 1; all other bits of A pass through unchanged.
  - Out of range, signed(B) < 0 or signed(B) ≥ BITS: o_result='0, o_error=1.
  - o_valid=1 in both cases.
- Range check: uses the full BITS-bit value of B. Any 1 in the upper bits (for BITS=32, bits 31..5), including the sign bit, is out of range; no truncation or modulo of B.
- Idle: on a rising edge with i_rst=0 and i_valid=0, o_result and o_error hold their previous values and o_valid=0.
- Latency: exactly 1 clock from i_valid to o_valid; throughput 1 operation per cycle; back-to-back i_valid is allowed.
- Outputs are driven only from registers; no combinational path from inputs to outputs.
- No X propagation: every output is defined in every cycle after the first reset.

Test Plan:
- Reset: i_rst=1 for 2 cycles with i_valid=1, A=32'hFFFFFFFF -> o_result=0, o_error=0, o_valid=0.
- In range from zero: A=0, B = 0, 5, 31 on consecutive cycles with i_valid=1.
  - Each following cycle: o_result = 32'h00000001, 32'h00000020, 32'h80000000; o_error=0; o_valid=1.
- Already-set bit and passthrough:
  - A=32'h0000_00F0, B=4 -> o_result=32'h0000_00F0, o_error=0.
  - A=32'hA5A5_0000, B=0 -> o_result=32'hA5A5_0001.
- Negative index: A=0, B = -1 (32'hFFFFFFFF), -2147483647 (32'h80000001), -16 -> each: o_result=0, o_error=1, o_valid=1.
- Too-large index: A=0, B = 32, 33, 2147483647 -> each: o_error=1, o_result=0. Then B=31 on the next cycle -> o_error=0, o_result=32'h80000000 (error clears).
- Hold, then mid-stream reset:
  - Valid op A=0, B=3 -> o_result=8. Drop i_valid for 3 cycles -> o_result stays 8, o_error stays 0, o_valid=0.
  - Assert i_valid and i_rst together -> next cycle: all outputs 0.
